// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: synchronised, debounced keypad front end feeding a
// calculator-style BCD shift buffer with a sequential Horner BCD-to-binary converter.
module keypad_entry_buffer #(
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned VALUE_W         = 14,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [9:0]                          key_digit,
   input  logic                                key_back,
   input  logic                                key_clear,
   input  logic                                key_enter,
   output logic [4*NUM_DIGITS-1:0]             digits_bcd,
   output logic [$clog2(NUM_DIGITS+1)-1:0]     digit_count,
   output logic [VALUE_W-1:0]                  value,
   output logic                                busy,
   output logic [VALUE_W-1:0]                  value_out,
   output logic                                value_valid,
   output logic                                overflow,
   output logic                                key_error
);

   localparam int unsigned KEY_W   = 13;
   localparam int unsigned BUF_W   = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W   = $clog2(NUM_DIGITS + 1);
   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned K_BACK  = 10;
   localparam int unsigned K_CLEAR = 11;
   localparam int unsigned K_ENTER = 12;

   typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_e;

   logic [KEY_W-1:0]   raw_keys_c;
   logic [KEY_W-1:0]   sync1_q, s2_q, s2_prev_q;
   logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
   logic [KEY_W-1:0]   db_q, db_d;
   logic [KEY_W-1:0]   ev_q;

   state_e             state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic [VALUE_W-1:0] value_out_q, value_out_d;
   logic [VALUE_W-1:0] acc_q, acc_d, acc_next_c;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               busy_q, busy_d;
   logic               vv_q, vv_d;
   logic               ov_q, ov_d;
   logic               ke_q, ke_d;
   logic [3:0]         ndig_c;
   logic [3:0]         dig_c;

   assign raw_keys_c = {key_enter, key_clear, key_back, key_digit};

   // Synchroniser, stability tracking, debounced vector and rising-edge events
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= '0;
         s2_q      <= '0;
         s2_prev_q <= '0;
         db_cnt_q  <= '0;
         db_q      <= '0;
         ev_q      <= '0;
      end else begin
         sync1_q   <= raw_keys_c;
         s2_q      <= sync1_q;
         s2_prev_q <= s2_q;
         db_cnt_q  <= db_cnt_d;
         db_q      <= db_d;
         ev_q      <= db_d & ~db_q;
      end
   end

   // Accept the synchronised vector once it has been equal for DEBOUNCE_CYCLES edges
   always_comb begin
      db_cnt_d = db_cnt_q;
      db_d     = db_q;
      if (s2_q != s2_prev_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         db_d = s2_q;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   // FSM state and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         value_q     <= '0;
         value_out_q <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         vv_q        <= 1'b0;
         ov_q        <= 1'b0;
         ke_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         value_q     <= value_d;
         value_out_q <= value_out_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         vv_q        <= vv_d;
         ov_q        <= ov_d;
         ke_q        <= ke_d;
      end
   end

   // Event decode with CLEAR > ENTER > BACK > digit priority, and Horner conversion
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      value_d     = value_q;
      value_out_d = value_out_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      vv_d        = 1'b0;
      ov_d        = 1'b0;
      ke_d        = 1'b0;
      ndig_c      = 4'd0;
      dig_c       = 4'd0;
      acc_next_c  = acc_q * VALUE_W'(10) + VALUE_W'(buf_q[{idx_q, 2'b00} +: 4]);

      for (int i = 0; i < 10; i++) begin
         if (ev_q[i]) begin
            ndig_c = ndig_c + 4'd1;
            dig_c  = 4'(i);
         end
      end

      case (state_q)
         IDLE: begin
            if (ev_q[K_CLEAR]) begin
               buf_d   = '0;
               cnt_d   = '0;
               value_d = '0;
            end else if (ev_q[K_ENTER]) begin
               if (cnt_q != '0) begin
                  value_out_d = value_q;
                  vv_d        = 1'b1;
                  buf_d       = '0;
                  cnt_d       = '0;
                  value_d     = '0;
               end
            end else if (ev_q[K_BACK]) begin
               if (cnt_q != '0) begin
                  buf_d   = buf_q >> 4;
                  cnt_d   = cnt_q - CNT_W'(1);
                  acc_d   = '0;
                  idx_d   = IDX_W'(NUM_DIGITS - 1);
                  state_d = CONV;
               end
            end else if (ndig_c > 4'd1) begin
               ke_d = 1'b1;
            end else if (ndig_c == 4'd1) begin
               if (cnt_q == CNT_W'(NUM_DIGITS)) begin
                  ov_d = 1'b1;
               end else begin
                  buf_d   = {buf_q[BUF_W-5:0], dig_c};
                  cnt_d   = cnt_q + CNT_W'(1);
                  acc_d   = '0;
                  idx_d   = IDX_W'(NUM_DIGITS - 1);
                  state_d = CONV;
               end
            end
         end
         CONV: begin
            ke_d  = |ev_q;
            acc_d = acc_next_c;
            if (idx_q == '0) begin
               value_d = acc_next_c;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CONV);
   end

   assign digits_bcd  = buf_q;
   assign digit_count = cnt_q;
   assign value       = value_q;
   assign busy        = busy_q;
   assign value_out   = value_out_q;
   assign value_valid = vv_q;
   assign overflow    = ov_q;
   assign key_error   = ke_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// tb_keypad_entry_buffer: scenario tasks checked against a digit-list reference model.
module tb_keypad_entry_buffer;

   localparam int unsigned ND = 4;
   localparam int unsigned VW = 14;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  key_digit;
   logic        key_back, key_clear, key_enter;
   logic [15:0] digits_bcd;
   logic [2:0]  digit_count;
   logic [13:0] value, value_out;
   logic        busy, value_valid, overflow, key_error;

   logic [9:0]  f_key_digit;
   logic        f_key_back, f_key_clear, f_key_enter;
   logic [15:0] f_digits_bcd;
   logic [2:0]  f_digit_count;
   logic [13:0] f_value, f_value_out;
   logic        f_busy, f_value_valid, f_overflow, f_key_error;

   always #5 clk = ~clk;

   keypad_entry_buffer #(.NUM_DIGITS(ND), .VALUE_W(VW), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .key_digit(key_digit), .key_back(key_back),
      .key_clear(key_clear), .key_enter(key_enter), .digits_bcd(digits_bcd),
      .digit_count(digit_count), .value(value), .busy(busy), .value_out(value_out),
      .value_valid(value_valid), .overflow(overflow), .key_error(key_error));

   // Short-debounce instance: only here can a second event land inside a conversion
   keypad_entry_buffer #(.NUM_DIGITS(ND), .VALUE_W(VW), .DEBOUNCE_CYCLES(1)) dut_fast (
      .clk(clk), .reset_n(reset_n), .key_digit(f_key_digit), .key_back(f_key_back),
      .key_clear(f_key_clear), .key_enter(f_key_enter), .digits_bcd(f_digits_bcd),
      .digit_count(f_digit_count), .value(f_value), .busy(f_busy), .value_out(f_value_out),
      .value_valid(f_value_valid), .overflow(f_overflow), .key_error(f_key_error));

   int checks = 0;
   int errors = 0;

   // Reference model: entered digits, oldest (most significant) first
   int m_dig[$];
   int m_value_out = 0;
   int exp_vv = 0, exp_ov = 0, exp_ke = 0;

   // Pulse monitors
   int cnt_vv = 0, cnt_ov = 0, cnt_ke = 0, f_cnt_ke = 0, wide = 0;
   logic vv_p = 1'b0, ov_p = 1'b0, ke_p = 1'b0, fke_p = 1'b0;

   always @(negedge clk) begin
      if (value_valid) cnt_vv <= cnt_vv + 1;
      if (overflow)    cnt_ov <= cnt_ov + 1;
      if (key_error)   cnt_ke <= cnt_ke + 1;
      if (f_key_error) f_cnt_ke <= f_cnt_ke + 1;
      if ((value_valid && vv_p) || (overflow && ov_p) || (key_error && ke_p) || (f_key_error && fke_p))
         wide <= wide + 1;
      vv_p  <= value_valid;
      ov_p  <= overflow;
      ke_p  <= key_error;
      fke_p <= f_key_error;
   end

   function automatic int model_value();
      int v = 0;
      foreach (m_dig[i]) v = (v * 10 + m_dig[i]) % (1 << VW);
      return v;
   endfunction

   function automatic logic [47:0] exp_state();
      logic [15:0] b = '0;
      int n = m_dig.size();
      for (int k = 0; k < n; k++) b[4*k +: 4] = 4'(m_dig[n-1-k]);
      return {b, 3'(n), 14'(model_value()), 1'b0, 14'(m_value_out)};
   endfunction

   function automatic void model_key(input logic [12:0] v);
      int pop = 0;
      int d = 0;
      for (int i = 0; i < 10; i++) if (v[i]) begin pop++; d = i; end
      if (v[11]) m_dig.delete();
      else if (v[12]) begin
         if (m_dig.size() != 0) begin
            m_value_out = model_value();
            exp_vv++;
            m_dig.delete();
         end
      end else if (v[10]) begin
         if (m_dig.size() != 0) void'(m_dig.pop_back());
      end else if (pop > 1) exp_ke++;
      else if (pop == 1) begin
         if (m_dig.size() == ND) exp_ov++;
         else m_dig.push_back(d);
      end
   endfunction

   function automatic logic [47:0] act_state();
      return {digits_bcd, digit_count, value, busy, value_out};
   endfunction

   task automatic drive(input logic [12:0] v);
      key_digit = v[9:0];
      key_back  = v[10];
      key_clear = v[11];
      key_enter = v[12];
   endtask

   task automatic press(input logic [12:0] v);
      @(negedge clk);
      drive(v);
      repeat (14) @(negedge clk);
      drive(13'h0);
      repeat (14) @(negedge clk);
      model_key(v);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(13'h0);
      f_key_digit = '0; f_key_back = 1'b0; f_key_clear = 1'b0; f_key_enter = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({act_state(), value_valid, overflow, key_error} !== 51'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {act_state(), value_valid, overflow, key_error});
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_entry();
      for (int d = 1; d <= 4; d++) press(13'(1 << d));
      checks++;
      if (act_state() !== exp_state() || digits_bcd !== 16'h1234 || value !== 14'd1234) begin
         errors++;
         $display("FAIL entry_1234: got %h expected %h", act_state(), exp_state());
      end
      press(13'(1 << 5));
      checks++;
      if (cnt_ov !== exp_ov || exp_ov != 1 || act_state() !== exp_state()) begin
         errors++;
         $display("FAIL overflow: got ov=%0d state=%h expected ov=%0d state=%h", cnt_ov, act_state(), exp_ov, exp_state());
      end
      press(13'h400);
      checks++;
      if (act_state() !== exp_state() || digits_bcd !== 16'h0123 || value !== 14'd123) begin
         errors++;
         $display("FAIL back: got %h expected %h", act_state(), exp_state());
      end
      press(13'h1000);
      checks++;
      if (act_state() !== exp_state() || value_out !== 14'd123 || cnt_vv !== exp_vv) begin
         errors++;
         $display("FAIL enter: got %h vv=%0d expected %h vv=%0d", act_state(), cnt_vv, exp_state(), exp_vv);
      end
   endtask

   task automatic test_bounce();
      int lat = -1;
      press(13'h800);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         key_digit[7] = 1'b1;
         repeat (2) @(negedge clk);
         key_digit[7] = 1'b0;
         repeat (2) @(negedge clk);
      end
      checks++;
      if (digit_count !== 3'd0) begin
         errors++;
         $display("FAIL bounce_reject: got count %0d expected 0", digit_count);
      end
      key_digit[7] = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (lat < 0 && digit_count != 3'd0) lat = n;
      end
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL bounce_latency: got %0d edges expected 8", lat);
      end
      @(negedge clk);
      drive(13'h0);
      repeat (14) @(negedge clk);
      model_key(13'h080);
      checks++;
      if (act_state() !== exp_state() || digits_bcd !== 16'h0007) begin
         errors++;
         $display("FAIL bounce_single: got %h expected %h", act_state(), exp_state());
      end
   endtask

   task automatic test_multi();
      press(13'h028);
      checks++;
      if (cnt_ke !== exp_ke || act_state() !== exp_state()) begin
         errors++;
         $display("FAIL multi_digit: got ke=%0d state=%h expected ke=%0d state=%h", cnt_ke, act_state(), exp_ke, exp_state());
      end
      press(13'h800 | 13'h200);
      checks++;
      if (act_state() !== exp_state() || digit_count !== 3'd0) begin
         errors++;
         $display("FAIL clear_digit: got %h expected %h", act_state(), exp_state());
      end
   endtask

   task automatic test_empty();
      press(13'h1000);
      press(13'h400);
      checks++;
      if (cnt_vv !== exp_vv || act_state() !== exp_state()) begin
         errors++;
         $display("FAIL empty_enter_back: got vv=%0d state=%h expected vv=%0d state=%h", cnt_vv, act_state(), exp_vv, exp_state());
      end
      repeat (4) press(13'h200);
      checks++;
      if (act_state() !== exp_state() || value !== 14'd9999) begin
         errors++;
         $display("FAIL nines: got %h expected %h", act_state(), exp_state());
      end
   endtask

   task automatic test_random();
      logic [12:0] v;
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 9))
            6:       v = 13'h400;
            7:       v = 13'h800;
            8:       v = 13'h1000;
            9:       v = 13'($urandom) & 13'h1fff;
            default: v = 13'(1 << $urandom_range(0, 9));
         endcase
         if (v == 13'h0) v = 13'h001;
         press(v);
         checks++;
         if (act_state() !== exp_state()) begin
            errors++;
            $display("FAIL random_%0d key=%h: got %h expected %h", it, v, act_state(), exp_state());
         end
      end
      checks++;
      if (cnt_vv !== exp_vv || cnt_ov !== exp_ov || cnt_ke !== exp_ke) begin
         errors++;
         $display("FAIL random_pulses: got %0d/%0d/%0d expected %0d/%0d/%0d", cnt_vv, cnt_ov, cnt_ke, exp_vv, exp_ov, exp_ke);
      end
   endtask

   task automatic test_busy_drop();
      @(negedge clk);
      f_key_digit = 10'b00_0000_0010;
      repeat (2) @(negedge clk);
      f_key_digit = 10'b00_0000_0110;
      repeat (20) @(negedge clk);
      f_key_digit = '0;
      repeat (20) @(negedge clk);
      checks++;
      if (f_cnt_ke !== 1 || {f_digits_bcd, f_digit_count, f_value, f_busy} !== {16'h0001, 3'd1, 14'd1, 1'b0}) begin
         errors++;
         $display("FAIL busy_drop: got ke=%0d state=%h expected ke=1 state=%h", f_cnt_ke,
                  {f_digits_bcd, f_digit_count, f_value, f_busy}, {16'h0001, 3'd1, 14'd1, 1'b0});
      end
   endtask

   task automatic test_reset_mid_conv();
      bit seen = 0;
      press(13'h800);
      press(13'h010);
      @(negedge clk);
      drive(13'h004);
      for (int n = 0; n < 30 && !seen; n++) begin
         @(posedge clk);
         #1;
         if (busy) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL conv_start: got busy=0 expected busy=1 within 30 cycles");
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({act_state(), value_valid, overflow, key_error} !== 51'h0) begin
         errors++;
         $display("FAIL reset_mid_conv: got %h expected 0", {act_state(), value_valid, overflow, key_error});
      end
      drive(13'h0);
      m_dig.delete();
      m_value_out = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      press(13'h100);
      checks++;
      if (act_state() !== exp_state() || value !== 14'd8 || cnt_vv !== exp_vv) begin
         errors++;
         $display("FAIL after_reset: got %h expected %h", act_state(), exp_state());
      end
   endtask

   task automatic test_pulse_width();
      checks++;
      if (wide !== 0) begin
         errors++;
         $display("FAIL pulse_width: got %0d wide pulses expected 0", wide);
      end
   endtask

   initial begin
      test_reset();
      test_entry();
      test_bounce();
      test_multi();
      test_empty();
      test_random();
      test_busy_drop();
      test_reset_mid_conv();
      test_pulse_width();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
